// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every handshake and memory-side signal of the memory port arbiter.
//   master : the environment (CPU core requesters plus the memory array).
//            It drives requests, flush and mem_rdata, and receives grants,
//            responses and the memory strobes.
//   slave  : the arbiter itself.
// Fetch port : if_req, if_addr -> if_gnt, if_rvalid, if_rdata
// Data port  : d_req, d_we, d_addr, d_wdata, d_be -> d_gnt, d_rvalid, d_rdata
// Memory     : mem_en, mem_we, mem_addr, mem_be, mem_wdata <- mem_rdata
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int AW = 8
);
    logic          flush;

    logic          if_req;
    logic [29:0]   if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;

    logic          d_req;
    logic          d_we;
    logic [29:0]   d_addr;
    logic [31:0]   d_wdata;
    logic [3:0]    d_be;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport master (
        output flush,
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  flush,
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port word memory (1-cycle synchronous read) between the
// instruction-fetch port and the load/store data port. Arbitration is done
// every cycle: data wins by default, but after STARVE_MAX consecutive lost
// cycles a waiting fetch is forced through. Flush cancels a fetch grant and
// masks a fetch response in the same cycle; it never affects the data port.
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   bus  : mem_port_arbiter_if.slave (both requester ports + memory side)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW         = 8,
    parameter int STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    // Who owns the response slot next cycle; loads and stores are split so
    // the store completion can return zero data.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DLOAD,
        OWN_DSTORE
    } owner_e;

    owner_e        owner_q, owner_d;
    logic          valid_q;
    logic [SW-1:0] starveCnt_q, starveCnt_d;
    logic [31:0]   ifRdata_q;
    logic [31:0]   dRdata_q;

    logic          fetchPri;
    logic          dGnt;
    logic          ifGnt;
    logic          memEn;
    logic          dRvalid;
    logic          ifRvalid;
    logic [31:0]   dRdataOut;
    logic [31:0]   ifRdataOut;

    // Upper address bits are intentionally ignored so addresses wrap.
    logic          unusedAddrBits;
    assign unusedAddrBits = ^{bus.if_addr[29:AW], bus.d_addr[29:AW]};

    // Grants are gated with rst so nothing reaches memory during reset.
    always_comb begin
        fetchPri = (starveCnt_q == SW'(STARVE_MAX));
        dGnt     = ~rst & bus.d_req & ~(fetchPri & bus.if_req & ~bus.flush);
        ifGnt    = ~rst & bus.if_req & ~bus.flush & ~dGnt;
        memEn    = dGnt | ifGnt;
    end

    always_comb begin
        bus.mem_en    = memEn;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_be    = 4'b0000;
        bus.mem_wdata = 32'h0;
        if (dGnt) begin
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = bus.d_addr[AW-1:0];
            bus.mem_be    = bus.d_be;
            bus.mem_wdata = bus.d_wdata;
        end else if (ifGnt) begin
            bus.mem_addr  = bus.if_addr[AW-1:0];
            bus.mem_be    = 4'b1111;
        end
    end

    // Next owner and starvation count. A flushed cycle in which fetch loses
    // neither counts as starvation nor as fetch progress, so the count holds.
    always_comb begin
        owner_d = OWN_NONE;
        if (dGnt) begin
            owner_d = bus.d_we ? OWN_DSTORE : OWN_DLOAD;
        end else if (ifGnt) begin
            owner_d = OWN_IF;
        end

        starveCnt_d = starveCnt_q;
        if (ifGnt || !bus.if_req) begin
            starveCnt_d = '0;
        end else if (!bus.flush && dGnt && (starveCnt_q != SW'(STARVE_MAX))) begin
            starveCnt_d = starveCnt_q + SW'(1);
        end
    end

    // Response side: memory data is passed straight through in the rvalid
    // cycle and captured so the outputs hold it afterwards.
    always_comb begin
        dRvalid  = valid_q & ((owner_q == OWN_DLOAD) | (owner_q == OWN_DSTORE));
        ifRvalid = valid_q & (owner_q == OWN_IF) & ~bus.flush;

        dRdataOut = dRdata_q;
        if (dRvalid) begin
            dRdataOut = (owner_q == OWN_DSTORE) ? 32'h0 : bus.mem_rdata;
        end

        ifRdataOut = ifRvalid ? bus.mem_rdata : ifRdata_q;

        bus.d_gnt     = dGnt;
        bus.if_gnt    = ifGnt;
        bus.d_rvalid  = dRvalid;
        bus.if_rvalid = ifRvalid;
        bus.d_rdata   = dRdataOut;
        bus.if_rdata  = ifRdataOut;
    end

    // A reset in the middle of an access drops the pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= OWN_NONE;
            valid_q     <= 1'b0;
            starveCnt_q <= '0;
            ifRdata_q   <= 32'h0;
            dRdata_q    <= 32'h0;
        end else begin
            owner_q     <= owner_d;
            valid_q     <= memEn;
            starveCnt_q <= starveCnt_d;
            if (dRvalid) begin
                dRdata_q <= dRdataOut;
            end
            if (ifRvalid) begin
                ifRdata_q <= ifRdataOut;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Drives both requester ports and emulates the memory array. A reference
// model of the arbitration rules, the response queue and a shadow copy of
// memory predicts every grant, memory strobe and response each cycle.
// Directed phases follow the test plan, then randomized traffic with
// random flushes and occasional resets.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
    localparam int AW         = 8;
    localparam int STARVE_MAX = 3;
    localparam int DEPTH      = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW)) bus ();

    mem_port_arbiter #(
        .AW         (AW),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Memory array seen by the arbiter; garbage is returned when no read
    // was issued so stale-data bugs show up.
    logic [31:0] memArr [DEPTH];

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_be[b]) memArr[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
            bus.mem_rdata <= $urandom;
        end else if (bus.mem_en) begin
            bus.mem_rdata <= memArr[bus.mem_addr];
        end else begin
            bus.mem_rdata <= $urandom;
        end
    end

    // Requester-side stimulus variables.
    logic        rstDrv;
    logic        flushDrv;
    logic        ifReq;
    logic [29:0] ifAddr;
    logic        dReq;
    logic        dWe;
    logic [29:0] dAddr;
    logic [31:0] dWdata;
    logic [3:0]  dBe;

    // Reference model state.
    logic [31:0] refMem [DEPTH];
    int          starve;
    int          pendKind;   // 0 none, 1 fetch, 2 load, 3 store
    logic [31:0] pendData;
    logic [31:0] lastIf;
    logic [31:0] lastD;
    logic        obsIf;
    logic        obsD;

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus();
        rst         = rstDrv;
        bus.flush   = flushDrv;
        bus.if_req  = ifReq;
        bus.if_addr = ifAddr;
        bus.d_req   = dReq;
        bus.d_we    = dWe;
        bus.d_addr  = dAddr;
        bus.d_wdata = dWdata;
        bus.d_be    = dBe;
    endtask

    // One clock cycle: drive, predict, compare at the falling edge, advance
    // the model, then return just after the next rising edge.
    task automatic stepCycle();
        logic        fetchPri, expD, expIf, expIfRv, expDRv, ifReqNow;
        logic [45:0] expBus;
        logic [31:0] expIfRd, expDRd;
        logic [7:0]  wa;
        applyStimulus();
        if (rstDrv) begin
            pendKind = 0;
            starve   = 0;
            lastIf   = 32'h0;
            lastD    = 32'h0;
        end
        @(negedge clk);
        fetchPri = (starve == STARVE_MAX);
        expD     = !rstDrv && dReq && !(fetchPri && ifReq && !flushDrv);
        expIf    = !rstDrv && ifReq && !flushDrv && !expD;
        if (expD)       expBus = {1'b1, dWe, dBe, dAddr[7:0], dWdata};
        else if (expIf) expBus = {1'b1, 1'b0, 4'hF, ifAddr[7:0], 32'h0};
        else            expBus = '0;
        expDRv  = (pendKind >= 2);
        expIfRv = (pendKind == 1) && !flushDrv;
        expDRd  = expDRv ? ((pendKind == 3) ? 32'h0 : pendData) : lastD;
        expIfRd = expIfRv ? pendData : lastIf;

        obsIf = bus.if_gnt;
        obsD  = bus.d_gnt;
        checkOutput("grants", {62'h0, bus.if_gnt, bus.d_gnt}, {62'h0, expIf, expD});
        checkOutput("memBus", {18'h0, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata},
                    {18'h0, expBus});
        checkOutput("dResp", {31'h0, bus.d_rvalid, bus.d_rdata}, {31'h0, expDRv, expDRd});
        checkOutput("ifResp", {31'h0, bus.if_rvalid, bus.if_rdata}, {31'h0, expIfRv, expIfRd});

        if (expDRv)  lastD  = expDRd;
        if (expIfRv) lastIf = expIfRd;
        ifReqNow = ifReq;
        pendKind = 0;
        if (expD) begin
            wa = dAddr[7:0];
            if (dWe) begin
                for (int b = 0; b < 4; b++) begin
                    if (dBe[b]) refMem[wa][8*b +: 8] = dWdata[8*b +: 8];
                end
                pendKind = 3;
            end else begin
                pendKind = 2;
                pendData = refMem[wa];
            end
            dReq = 1'b0;
        end else if (expIf) begin
            pendKind = 1;
            pendData = refMem[ifAddr[7:0]];
            ifReq    = 1'b0;
        end
        if (!rstDrv) begin
            if (expIf || !ifReqNow)                             starve = 0;
            else if (!flushDrv && expD && starve < STARVE_MAX)  starve++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        ifReq    = 1'b0;
        dReq     = 1'b0;
        flushDrv = 1'b0;
        stepCycle();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            memArr[i] = $urandom;
            refMem[i] = memArr[i];
        end
        rstDrv = 1'b1; flushDrv = 1'b0;
        ifReq = 1'b1; ifAddr = 30'h1; dReq = 1'b1; dWe = 1'b0; dAddr = 30'h2;
        dWdata = 32'h0; dBe = 4'h0;
        starve = 0; pendKind = 0; pendData = 32'h0; lastIf = 32'h0; lastD = 32'h0;
        obsIf = 1'b0; obsD = 1'b0;
        applyStimulus();
        @(posedge clk);
        #1;

        // Reset held with requests pending: no grants, no responses.
        stepCycle();
        stepCycle();
        rstDrv = 1'b0;
        idleCycle();

        // Back-to-back fetches of words 0..7.
        for (int i = 0; i < 8; i++) begin
            ifReq  = 1'b1;
            ifAddr = 30'(i);
            stepCycle();
        end
        idleCycle();

        // Store then load of word 5.
        dReq = 1'b1; dWe = 1'b1; dAddr = 30'h5; dWdata = 32'hDEADBEEF; dBe = 4'hF;
        stepCycle();
        dReq = 1'b1; dWe = 1'b0; dAddr = 30'h5;
        stepCycle();
        idleCycle();
        checkOutput("loadBack", {32'h0, lastD}, {32'h0, 32'hDEADBEEF});

        // Continuous contention: D,D,D,IF repeating.
        for (int i = 0; i < 8; i++) begin
            ifReq = 1'b1; ifAddr = 30'(16 + i);
            dReq  = 1'b1; dWe = 1'b0; dAddr = 30'(32 + i);
            stepCycle();
            checkOutput("arbSeq", {62'h0, obsIf, obsD}, (i % 4 == 3) ? 64'h2 : 64'h1);
        end
        idleCycle();

        // Fetch granted, then flush the next cycle while D still proceeds.
        ifReq = 1'b1; ifAddr = 30'h3;
        stepCycle();
        flushDrv = 1'b1;
        ifReq = 1'b1; ifAddr = 30'h4;
        dReq  = 1'b1; dWe = 1'b0; dAddr = 30'h6;
        stepCycle();
        checkOutput("flushGnt", {62'h0, obsIf, obsD}, 64'h1);
        flushDrv = 1'b0;
        stepCycle();
        idleCycle();

        // Reset right after a load grant drops its response.
        dReq = 1'b1; dWe = 1'b0; dAddr = 30'h9;
        stepCycle();
        rstDrv = 1'b1;
        dReq = 1'b1; dAddr = 30'hA; ifReq = 1'b1; ifAddr = 30'hB;
        stepCycle();
        rstDrv = 1'b0;
        stepCycle();
        idleCycle();

        // Address wrap: 0x105 reaches word 5.
        dReq = 1'b1; dWe = 1'b0; dAddr = 30'h105;
        stepCycle();
        idleCycle();
        checkOutput("wrapLoad", {32'h0, lastD}, {32'h0, refMem[5]});

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            if (!ifReq && ($urandom_range(0, 1) == 1)) begin
                ifReq  = 1'b1;
                ifAddr = 30'($urandom);
            end
            if (!dReq && ($urandom_range(0, 1) == 1)) begin
                dReq   = 1'b1;
                dWe    = 1'($urandom_range(0, 1));
                dAddr  = 30'($urandom);
                dWdata = $urandom;
                dBe    = 4'($urandom);
            end
            flushDrv = ($urandom_range(0, 7) == 0);
            rstDrv   = ($urandom_range(0, 99) == 0);
            stepCycle();
        end
        rstDrv = 1'b0;
        idleCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single-port word memory between two requesters: the instruction-fetch port (IF) and the load/store data port (D).
- Replaces the fixed fetch/execute alternation with per-cycle arbitration, so back-to-back accesses are possible.
- Data has priority; a starvation counter guarantees fetch progress.
- A flush input (exception entry or eret) discards an in-flight fetch response.
- Sits between the CPU core and the memory array; the memory has a 1-cycle synchronous read latency.

Parameters:
- AW, 8: memory word-address width; only the low AW bits of the 30-bit word addresses are used, so higher addresses wrap.
- STARVE_MAX, 3: number of consecutive cycles fetch may lose arbitration before it is forced to win.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  cancel fetch grant/response this cycle (exception entry or eret)
- if_req  in  1  fetch request
- if_addr  in  30  fetch word address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid (cycle after grant)
- if_rdata  out  32  fetch data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  30  data word address
- d_wdata  in  32  store data
- d_be  in  4  store byte enables
- d_gnt  out  1  data access accepted this cycle
- d_rvalid  out  1  load data valid, or store completion (cycle after grant)
- d_rdata  out  32  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory word address
- mem_be  out  4  memory byte enables
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after an enabled read

Behaviour:
- Reset (async):
  - Clears owner_q (none), valid_q=0, starve_cnt=0, if_rdata_q=0, d_rdata_q=0.
  - While rst is high, if_gnt, d_gnt and mem_en are forced to 0.
  - After rst: rvalid=0, rdata=0.
- Arbitration (combinational, same cycle as req):
  - fetch_pri = (starve_cnt == STARVE_MAX).
  - d_gnt = d_req & ~(fetch_pri & if_req & ~flush).
  - if_gnt = if_req & ~flush & ~d_gnt.
  - At most one grant per cycle; one access per cycle at full throughput.
- Memory drive (combinational from the granted port):
  - mem_en = d_gnt | if_gnt.
  - D granted: mem_addr = d_addr[AW-1:0], mem_we = d_we, mem_be = d_be, mem_wdata = d_wdata.
  - IF granted: mem_we = 0, mem_be = 4'b1111, mem_wdata = 0.
  - Idle: mem_addr = 0, mem_we = 0, mem_be = 0, mem_wdata = 0.
- Response pipeline:
  - On each clk edge, owner_q <= granted port (or none) and valid_q <= mem_en.
  - Cycle T+1 after a grant in cycle T:
    - owner D: d_rvalid = 1, for both loads and stores.
    - owner IF: if_rvalid = 1 & ~flush.
  - During rvalid, rdata = mem_rdata (D stores: d_rdata = 0). Otherwise rdata holds its registered last value, captured at the clk edge ending the rvalid cycle.
  - Suppressed fetch responses do not update if_rdata_q.
- Starvation counter:
  - if_req & ~flush & ~if_gnt & d_gnt: starve_cnt++, saturating at STARVE_MAX.
  - if_gnt or ~if_req: starve_cnt <= 0.
  - flush with no grant: counter holds.
- Flush:
  - Blocks if_gnt in the same cycle and masks if_rvalid in the same cycle.
  - Has no effect on D.
  - A fetch granted during flush is impossible by construction.
- Boundary cases:
  - Simultaneous d_req & if_req with fetch_pri=1 → IF wins; D must hold its request.
  - Address wrap: an address of 2^AW+k accesses word k.
  - rst mid-access: the pending response is dropped with no rvalid; the memory write issued in the same cycle may or may not have occurred.
- Requesters hold req/addr/data stable until gnt; arbiter behaviour with unstable requests is undefined.

Test Plan:
- After reset, drive if_req=1, if_addr=0..7 every cycle, d_req=0 → if_gnt every cycle; if_rvalid one cycle later with if_rdata equal to memory words 0..7 in order.
- Store d_addr=5, d_wdata=0xDEADBEEF, d_be=4'hF, then load d_addr=5 → both d_gnt=1, d_rvalid on the following cycles, load d_rdata=0xDEADBEEF; store d_rdata=0.
- Hold if_req=1 and d_req=1 continuously with STARVE_MAX=3 → grant sequence D,D,D,IF,D,D,D,IF repeating; starve_cnt returns to 0 after each IF grant.
- Fetch granted at T, flush=1 at T+1 → if_rvalid=0 at T+1 and if_rdata keeps its prior value; if_req with flush=1 → if_gnt=0 while d_gnt still follows d_req.
- Assert rst for 1 cycle mid-stream after a D load grant → no d_rvalid; all rvalid=0, rdata=0, starve_cnt=0; gnt outputs=0 while rst is high.
- Load d_addr=0x105 with AW=8 → mem_addr=0x05, d_rdata equals word 5.
